// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle carrying the imem request/response, redirect and IF-register handoff.
// The master modport is the fetch unit; slave is its environment (imem, branch unit, IF register).
interface if_fetch_unit_if #(
    parameter int unsigned Xlen = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [Xlen-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [Xlen-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [Xlen-1:0] redirect_pc;
    logic            fetch_valid;
    logic [Xlen-1:0] fetch_pc;
    logic [Xlen-1:0] fetch_instr;
    logic            fetch_ready;

    modport master (
        output imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               fetch_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               fetch_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// PC generator and instruction prefetch stage feeding the IF pipeline register.
// Defining FETCH_PERF_EN adds saturating pop and bubble counters as extra outputs.
module if_fetch_unit #(
    parameter int unsigned     Xlen           = 32,
    parameter logic [Xlen-1:0] ResetPc        = '0,
    parameter int unsigned     FifoDepth      = 4,
    parameter int unsigned     MaxOutstanding = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetch_cycles_o,
    output logic [31:0]     perf_bubble_cycles_o,
`endif
    if_fetch_unit_if.master bus_io
);
    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    logic [Xlen-1:0] pc_q, pc_d;
    logic [Xlen-1:0] rsp_pc_q, rsp_pc_d;
    logic [OutW-1:0] out_q, out_d;
    logic [OutW-1:0] drop_q, drop_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [Xlen-1:0] pc_mem_q    [FifoDepth];
    logic [Xlen-1:0] instr_mem_q [FifoDepth];

    logic            redirect;
    logic [Xlen-1:0] redirect_pc;
    logic            req_valid;
    logic            req_hs;
    logic            rsp_valid;
    logic            push;
    logic            pop;
    logic            fetch_valid;
    logic            unused_redirect_lsb;

    assign redirect            = bus_io.redirect_valid;
    assign redirect_pc         = {bus_io.redirect_pc[Xlen-1:2], 2'b00};
    assign unused_redirect_lsb = ^bus_io.redirect_pc[1:0];
    assign rsp_valid           = bus_io.imem_rsp_valid;

    // Credit check: every issued request is guaranteed a FIFO slot when it returns.
    assign req_valid = rst_ni && !redirect && (out_q < OutW'(MaxOutstanding)) &&
                       ((32'(out_q) + 32'(count_q)) < FifoDepth);
    assign req_hs    = req_valid && bus_io.imem_req_ready;

    assign fetch_valid = (count_q != '0) && !redirect;
    assign push        = rsp_valid && (drop_q == '0) && !redirect;
    assign pop         = fetch_valid && bus_io.fetch_ready;

    assign bus_io.imem_req_valid = req_valid;
    assign bus_io.imem_req_addr  = pc_q;
    assign bus_io.fetch_valid    = fetch_valid;
    assign bus_io.fetch_pc       = pc_mem_q[rd_ptr_q];
    assign bus_io.fetch_instr    = instr_mem_q[rd_ptr_q];

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q;
        drop_d   = drop_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d     = redirect_pc;
            rsp_pc_d = redirect_pc;
            out_d    = out_q - OutW'(rsp_valid);
            drop_d   = out_q - OutW'(rsp_valid);
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (req_hs) begin
                pc_d = pc_q + Xlen'(4);
            end
            out_d = out_q + OutW'(req_hs) - OutW'(rsp_valid);
            if (rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - OutW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                rsp_pc_d = rsp_pc_q + Xlen'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= ResetPc;
            rsp_pc_q <= ResetPc;
            out_q    <= '0;
            drop_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < FifoDepth; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
                instr_mem_q[wr_ptr_q] <= bus_io.imem_rsp_data;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_bubble_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (pop && (perf_fetch_q != 32'hFFFF_FFFF)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (bus_io.fetch_ready && !fetch_valid && (perf_bubble_q != 32'hFFFF_FFFF)) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cycles_o  = perf_fetch_q;
    assign perf_bubble_cycles_o = perf_bubble_q;
`else
    // Perf counters compiled out.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: fixed-latency imem model, output scoreboard,
// a cycle table for the stall/release case and hand sequences for redirects and reset.
module tb_if_fetch_unit;
    logic clk;
    logic rst_ni;

    if_fetch_unit_if #(.Xlen(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    if_fetch_unit #(
        .Xlen          (32),
        .ResetPc       (32'h0),
        .FifoDepth     (4),
        .MaxOutstanding(4)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
`ifdef FETCH_PERF_EN
        .perf_fetch_cycles_o (perf_fetch),
        .perf_bubble_cycles_o(perf_bubble),
`endif
        .bus_io              (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        fr;
        logic        rv;
        logic [31:0] ra;
        logic        fv;
        logic [31:0] fpc;
    } vec_t;

    req_t        pend[$];
    exp_t        exp_q[$];
    logic [31:0] pop_log[$];
    vec_t        vecs[16];

    int checks;
    int failures;
    int cyc;
    int lat;

    logic        obs_rv;
    logic        obs_fv;
    logic [31:0] obs_ra;
    logic [31:0] obs_fpc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return (addr * 32'd3) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, run imem model, sample at negedge, score pops.
    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic fr);
        req_t e;
        exp_t x;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.fetch_ready    = fr;
        if (redir) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_q.delete();
        end
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            e = pend.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(e.addr);
            if (!e.stale) begin
                x.pc    = e.addr;
                x.instr = instr_of(e.addr);
                exp_q.push_back(x);
            end
        end
        @(negedge clk);
        obs_rv  = bus.imem_req_valid;
        obs_ra  = bus.imem_req_addr;
        obs_fv  = bus.fetch_valid;
        obs_fpc = bus.fetch_pc;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            e.addr  = bus.imem_req_addr;
            e.due   = cyc + lat;
            e.stale = 1'b0;
            pend.push_back(e);
        end
        if (bus.fetch_valid && bus.fetch_ready) begin
            pop_log.push_back(bus.fetch_pc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_pop: got pc %h expected no output", bus.fetch_pc);
            end else begin
                x = exp_q.pop_front();
                check("sb_pc", bus.fetch_pc, x.pc);
                check("sb_instr", bus.fetch_instr, x.instr);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1);
    endtask

    task automatic check_pops(input string name, input logic [31:0] first, input int n);
        check({name, "_count_ok"}, 32'(pop_log.size() >= n), 32'd1);
        for (int i = 0; i < n && i < pop_log.size(); i++) begin
            check($sformatf("%s_pop%0d", name, i), pop_log[i], first + 32'(4 * i));
        end
    endtask

    // Asserts reset (taking effect immediately), checks reset outputs, releases at posedge+1.
    task automatic do_reset(input string name);
        rst_ni             = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.fetch_ready    = 1'b0;
        pend.delete();
        exp_q.delete();
        pop_log.delete();
        #1;
        check({name, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check({name, "_req_addr"}, bus.imem_req_addr, 32'h0);
        check({name, "_fetch_valid"}, 32'(bus.fetch_valid), 32'd0);
        check({name, "_fetch_pc"}, bus.fetch_pc, 32'h0);
        check({name, "_fetch_instr"}, bus.fetch_instr, 32'h0);
`ifdef FETCH_PERF_EN
        check({name, "_perf_fetch"}, perf_fetch, 32'h0);
        check({name, "_perf_bubble"}, perf_bubble, 32'h0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        lat      = 1;

        // Stall then release, cycle by cycle from reset release: {fr, req_v, addr, fv, pc}.
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
        for (int i = 4; i < 10; i++) vecs[i] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[10] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[11] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
        vecs[12] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        vecs[13] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[14] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[15] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

        // Streaming with single-cycle imem.
        do_reset("rst0");
        lat = 1;
        for (int n = 0; n < 10; n++) begin
            cycle(1'b0, 32'h0, 1'b1);
            check($sformatf("stream%0d_fv", n), 32'(obs_fv), 32'(n >= 2));
            if (n >= 2) check($sformatf("stream%0d_pc", n), obs_fpc, 32'(4 * (n - 2)));
        end

        // Stall with full FIFO, then release.
        do_reset("rst1");
        lat = 1;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 32'h0, vecs[i].fr);
            check($sformatf("tbl%0d_req_valid", i), 32'(obs_rv), 32'(vecs[i].rv));
            check($sformatf("tbl%0d_req_addr", i), obs_ra, vecs[i].ra);
            check($sformatf("tbl%0d_fetch_valid", i), 32'(obs_fv), 32'(vecs[i].fv));
            if (vecs[i].fv) check($sformatf("tbl%0d_fetch_pc", i), obs_fpc, vecs[i].fpc);
        end
        check_pops("tbl_release", 32'h0, 6);

        // Three in flight with 3-cycle imem; redirect coincides with the first response.
        do_reset("rst2");
        lat = 3;
        run(3);
        pop_log.delete();
        cycle(1'b1, 32'h100, 1'b1);
        check("redir_no_req", 32'(obs_rv), 32'd0);
        check("redir_no_fv", 32'(obs_fv), 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        check("redir_next_req_valid", 32'(obs_rv), 32'd1);
        check("redir_next_req_addr", obs_ra, 32'h100);
        run(10);
        check_pops("redir", 32'h100, 3);

        // Redirect on a cycle with a response arriving and a pop pending.
        do_reset("rst3");
        lat = 1;
        run(5);
        pop_log.delete();
        cycle(1'b1, 32'h40, 1'b1);
        check("pend_pop_fv", 32'(obs_fv), 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        check("pend_flushed_fv", 32'(obs_fv), 32'd0);
        run(6);
        check_pops("pend", 32'h40, 3);

        // Back-to-back redirects; low address bits of the second one ignored.
        do_reset("rst4");
        lat = 3;
        run(4);
        pop_log.delete();
        cycle(1'b1, 32'h200, 1'b1);
        cycle(1'b1, 32'h303, 1'b1);
        run(14);
        check_pops("b2b", 32'h300, 3);

        // PC wrap at the top of the address space.
        do_reset("rst5");
        lat = 1;
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        run(10);
        check_pops("wrap", 32'hFFFF_FFF8, 4);

        // Reset asserted mid-stream with two requests in flight.
        do_reset("rst6");
        lat = 3;
        run(2);
        do_reset("rst_mid");
        lat = 1;
        cycle(1'b0, 32'h0, 1'b1);
        check("restart_req_valid", 32'(obs_rv), 32'd1);
        check("restart_req_addr", obs_ra, 32'h0);
        run(6);
        check_pops("restart", 32'h0, 4);
`ifdef FETCH_PERF_EN
        check("perf_fetch_count", perf_fetch, 32'(pop_log.size()));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
